// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Shared 640x480@60 raster constants and axis state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    localparam int POS_W = 10;

    localparam int C_H_ACTIVE = 640;
    localparam int C_H_FP     = 16;
    localparam int C_H_SYNC   = 96;
    localparam int C_H_BP     = 48;

    localparam int C_V_ACTIVE = 480;
    localparam int C_V_FP     = 10;
    localparam int C_V_SYNC   = 2;
    localparam int C_V_BP     = 33;

    typedef enum logic [1:0] {
        AXIS_ACTIVE = 2'd0,
        AXIS_FRONT  = 2'd1,
        AXIS_SYNC   = 2'd2,
        AXIS_BACK   = 2'd3
    } axis_state_t;

    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_timer.sv
`default_nettype none
// ============================================================================
// Module      : vga_axis_timer
// Description : One raster axis: position counter, porch/sync FSM and
//               registered sync/active flags aligned with the count.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_timer
    import vga_timing_pkg::*;
#(
    parameter int   ACTIVE   = C_H_ACTIVE,
    parameter int   FP       = C_H_FP,
    parameter int   SYNC     = C_H_SYNC,
    parameter int   BP       = C_H_BP,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             adv,
    output logic [POS_W-1:0] count,
    output logic             sync,
    output logic             active,
    output logic             wrap
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

    localparam logic [POS_W-1:0] C_LAST        = POS_W'(TOTAL - 1);
    localparam logic [POS_W-1:0] C_FRONT_START = POS_W'(ACTIVE);
    localparam logic [POS_W-1:0] C_SYNC_START  = POS_W'(ACTIVE + FP);
    localparam logic [POS_W-1:0] C_BACK_START  = POS_W'(ACTIVE + FP + SYNC);

    generate
        if (TOTAL > (1 << POS_W)) begin : g_total_check
            $error("vga_axis_timer: axis total %0d exceeds counter range", TOTAL);
        end
    endgenerate

    logic [POS_W-1:0] r_count;
    logic [POS_W-1:0] w_count_next;
    axis_state_t      r_state;
    axis_state_t      w_state_next;
    logic             r_sync;
    logic             r_active;

    assign wrap = adv && (r_count == C_LAST);

    // Next state is decided from the next count so the registered flags
    // land on the same edge as the count they describe.
    always_comb begin
        w_count_next = wrap ? '0 : r_count + POS_W'(1);
        w_state_next = r_state;
        if (w_count_next == '0) begin
            w_state_next = AXIS_ACTIVE;
        end else if (w_count_next == C_BACK_START) begin
            w_state_next = AXIS_BACK;
        end else if (w_count_next == C_SYNC_START) begin
            w_state_next = AXIS_SYNC;
        end else if (w_count_next == C_FRONT_START) begin
            w_state_next = AXIS_FRONT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count  <= '0;
            r_state  <= AXIS_ACTIVE;
            r_sync   <= ~SYNC_POL;
            r_active <= 1'b1;
        end else if (adv) begin
            r_count  <= w_count_next;
            r_state  <= w_state_next;
            r_sync   <= (w_state_next == AXIS_SYNC) ? SYNC_POL : ~SYNC_POL;
            r_active <= (w_state_next == AXIS_ACTIVE);
        end
    end

    assign count  = r_count;
    assign sync   = r_sync;
    assign active = r_active;

endmodule
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_gen
// Description : VGA raster timing generator: position, syncs, active video,
//               line/frame strobes and an 8-bit frame counter.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = C_H_ACTIVE,
    parameter int   H_FP     = C_H_FP,
    parameter int   H_SYNC   = C_H_SYNC,
    parameter int   H_BP     = C_H_BP,
    parameter int   V_ACTIVE = C_V_ACTIVE,
    parameter int   V_FP     = C_V_FP,
    parameter int   V_SYNC   = C_V_SYNC,
    parameter int   V_BP     = C_V_BP,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pix_en,
    output logic [POS_W-1:0]    hpos,
    output logic [POS_W-1:0]    vpos,
    output logic                hsync,
    output logic                vsync,
    output logic                display_on,
    output logic                line_end,
    output logic                frame_end,
    output logic [7:0]          frame
);

    logic w_h_active;
    logic w_v_active;
    logic w_h_wrap;
    logic w_v_wrap;
    logic [7:0] r_frame;

    vga_axis_timer #(
        .ACTIVE   (H_ACTIVE),
        .FP       (H_FP),
        .SYNC     (H_SYNC),
        .BP       (H_BP),
        .SYNC_POL (SYNC_POL)
    ) u_h_axis (
        .clk    (clk),
        .reset  (reset),
        .adv    (pix_en),
        .count  (hpos),
        .sync   (hsync),
        .active (w_h_active),
        .wrap   (w_h_wrap)
    );

    // The vertical axis steps once per completed line.
    vga_axis_timer #(
        .ACTIVE   (V_ACTIVE),
        .FP       (V_FP),
        .SYNC     (V_SYNC),
        .BP       (V_BP),
        .SYNC_POL (SYNC_POL)
    ) u_v_axis (
        .clk    (clk),
        .reset  (reset),
        .adv    (w_h_wrap),
        .count  (vpos),
        .sync   (vsync),
        .active (w_v_active),
        .wrap   (w_v_wrap)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame <= 8'd0;
        end else if (w_v_wrap) begin
            r_frame <= r_frame + 8'd1;
        end
    end

    // Both inputs are registered flags, so this is a clean AND of flops.
    assign display_on = w_h_active & w_v_active;
    assign line_end   = w_h_wrap;
    assign frame_end  = w_v_wrap;
    assign frame      = r_frame;

endmodule
`default_nettype wire

// File: doc/vga_sync_gen.md
# vga_sync_gen

VGA raster timing generator feeding the pixel/pattern stage of `tt_um_mattvenn_vgatest`. It tracks horizontal and vertical position and produces sync pulses, the active-video flag, line/frame strobes and a frame counter. The pattern logic reads `hpos`/`vpos`/`display_on` to colour pixels and forwards `hsync`/`vsync` to `uo_out`. Default timing is 640x480@60 on the 25 MHz project clock.

## Interface

Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `SYNC_POL`, 0, asserted level of `hsync`/`vsync` (0 = active-low)

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high reset
- `pix_en` in 1: pixel advance enable; counters move only when high
- `hpos` out 10: current column, 0..H_TOTAL-1
- `vpos` out 10: current line, 0..V_TOTAL-1
- `hsync` out 1: horizontal sync at `SYNC_POL` level during the sync interval
- `vsync` out 1: vertical sync at `SYNC_POL` level during the sync interval
- `display_on` out 1: high when hpos<H_ACTIVE and vpos<V_ACTIVE
- `line_end` out 1: single-clock strobe on the last pixel of a line
- `frame_end` out 1: single-clock strobe on the last pixel of a frame
- `frame` out 8: frame counter, wraps mod 256

## Operation

- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be ≤1024; elaboration fails otherwise.
- Each axis runs a 4-state FSM: ACTIVE → FRONT → SYNC → BACK → ACTIVE. Transitions occur when the axis count crosses the corresponding boundary.
- Horizontal axis:
  - Advances when `pix_en` is high.
  - At hpos==H_TOTAL-1, wraps to 0 and issues one vertical advance.
- Vertical axis:
  - Advances only on a horizontal wrap.
  - At vpos==V_TOTAL-1, wraps to 0 and increments `frame`, which wraps from 255 to 0.
- Sync windows:
  - `hsync` is asserted for hpos in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
  - `vsync` is asserted for vpos in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491.
- `hsync`, `vsync` and `display_on` are registered and computed from next-state counts. They always match the current `hpos`/`vpos` in the same cycle, with no skew.
- Strobes:
  - `line_end` = `pix_en` & hpos==H_TOTAL-1.
  - `frame_end` = `line_end` & vpos==V_TOTAL-1.
  - Both are combinational from registers and `pix_en`, so each lasts exactly one clock per occurrence.
- Reset, including assertion mid-frame, immediately clears:
  - hpos=0, vpos=0, frame=0
  - hsync=vsync=~SYNC_POL (inactive)
  - display_on=1, both FSMs in ACTIVE
  - line_end=frame_end=0
- Output is fully deterministic from reset; no frame synchronisation state is kept.

## Timing

- Latency: zero. A counter update and its derived flags change on the same rising edge.
- With `pix_en` tied high, one line takes 800 clocks and one frame takes 420000 clocks.
- `pix_en` low holds every register. Strobes stay low while `pix_en` is low, even at the last pixel.
- Horizontal and vertical wrap on the same edge: hpos→0, vpos→0 and frame+1 all update together.
- After reset deasserts, the first `pix_en` edge moves hpos to 1.

## Structure

- Shared package `vga_timing_pkg`:
  - 640x480@60 constants
  - axis state enum (ACTIVE/FRONT/SYNC/BACK)
  - `POS_W`=10
- Sub-module `vga_axis_timer` (parameters ACTIVE/FP/SYNC/BP/SYNC_POL; ports adv, count, sync, active, wrap). It is instantiated twice:
  - horizontal: adv=`pix_en`
  - vertical: adv=horizontal wrap
- Top level holds the frame counter and strobe logic.

## Test plan

- Reset values: assert `reset` mid-line at hpos=300, vpos=100 → same clock: hpos=0, vpos=0, frame=0, hsync=1, vsync=1, display_on=1, strobes 0.
- Hsync window: `pix_en`=1 → hsync falls at hpos=656, rises at hpos=752 (96 clocks low); display_on falls at hpos=640.
- Line wrap: after 799 advances hpos=799 and line_end=1 for one clock; next edge hpos=0, vpos=1, line_end=0.
- Vsync window: vsync low exactly while vpos∈{490,491}, i.e. 1600 clocks; display_on low for all of vpos≥480.
- Frame wrap: at clock 419999 frame_end=1; next edge hpos=0, vpos=0, frame=1; preload to frame=255 → wraps to 0.
- Stall: drop `pix_en` for 10 clocks at hpos=799, vpos=524 → all outputs hold and no strobes fire; raising `pix_en` → strobes fire once, then wrap.
